// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit add/subtract: one 4-bit ripple adder reused over the nibbles,
// least-significant first, with the inter-nibble carry held in a register.

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  logic [4:0] c;

  assign c[0] = c0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign c4 = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q;

  logic [3:0] op_a, op_b;
  logic [3:0] add_s;
  logic       add_c4;

  // Select the current nibble of each operand register.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        op_a = a_q[4*i +: 4];
        op_b = b_q[4*i +: 4];
      end
    end
  end

  four_bit_adder u_adder (
    .a  (op_a),
    .b  (op_b),
    .c0 (carry_q),
    .s  (add_s),
    .c4 (add_c4)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + ~borrow, so invert b and cin at capture.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[4*i +: 4] = add_s;
          end
        end
        carry_d = add_c4;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_c4;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule
